cr_kme_fifo_param: RTL and testbench

CR_KME_FIFO_PARAM -- requirements
Module: cr_kme_fifo_param

---
 rtl/cr_kme_fifo_pkg.sv | 19 +
 rtl/cr_kme_fifo_ram.sv | 26 ++
 rtl/cr_kme_fifo_param.sv | 143 ++++++++++++++
 tb/tb_cr_kme_fifo_param.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_kme_fifo_pkg.sv
// rtl/cr_kme_fifo_pkg.sv - shared parameter limits and sizing helpers for cr_kme_fifo_param
package cr_kme_fifo_pkg;

    localparam int DATA_W_MIN = 1;
    localparam int DATA_W_MAX = 512;
    localparam int DEPTH_MIN  = 2;
    localparam int DEPTH_MAX  = 64;

    // Width of an occupancy count that must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a storage index; at least one bit so tiny depths still elaborate.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cr_kme_fifo_ram.sv
// rtl/cr_kme_fifo_ram.sv - DATA_W x DEPTH storage, one write port, one asynchronous read port
module cr_kme_fifo_ram #(
    parameter int DATA_W = 106,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is never reset; the controller's occupancy decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cr_kme_fifo_param.sv
// rtl/cr_kme_fifo_param.sv - parameterised FWFT FIFO with stall reserve; CR_KME_FIFO_OUT_REG_EN adds a registered output stage
module cr_kme_fifo_param
    import cr_kme_fifo_pkg::*;
#(
    parameter int DATA_W        = 106,
    parameter int DEPTH         = 4,
    parameter int STALL_RESERVE = 0,
    localparam int CNT_W        = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [DATA_W-1:0] fifo_in,
    input  logic              fifo_in_valid,
    input  logic              fifo_in_stall_override,
    output logic              fifo_in_stall,
    output logic [DATA_W-1:0] fifo_out,
    output logic              fifo_out_valid,
    input  logic              fifo_out_ack,
    output logic [CNT_W-1:0]  used_slots,
    output logic [CNT_W-1:0]  free_slots,
    output logic              fifo_overflow,
    output logic              fifo_underflow
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] RESERVE_C = CNT_W'(STALL_RESERVE);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
        $error("cr_kme_fifo_param: DATA_W out of range");
    end
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("cr_kme_fifo_param: DEPTH out of range");
    end
    if (STALL_RESERVE < 0 || STALL_RESERVE > DEPTH - 1) begin : g_bad_reserve
        $error("cr_kme_fifo_param: STALL_RESERVE out of range");
    end

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  used_q;
    logic [CNT_W-1:0]  free_q;
    logic              ovf_q;
    logic              udf_q;
    logic              full;
    logic              ren;
    logic              wr_acc;
    logic              ram_rd;
    logic [DATA_W-1:0] ram_rd_data;

    // Pointers run 0..DEPTH-1 and wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full   = (used_q == DEPTH_C);
    assign ren    = fifo_out_valid & fifo_out_ack;
    // A pop in the same cycle frees the slot, so a write at full is still taken.
    assign wr_acc = fifo_in_valid & (~full | ren);

    cr_kme_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc & ~rst & ~clear),
        .wr_addr (wr_ptr),
        .wr_data (fifo_in),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    // Pointer, occupancy and error-pulse bookkeeping; clear behaves like reset but is a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used_q <= '0;
            free_q <= DEPTH_C;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used_q <= '0;
            free_q <= DEPTH_C;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (ram_rd) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            used_q <= used_q + CNT_W'(wr_acc) - CNT_W'(ren);
            free_q <= free_q - CNT_W'(wr_acc) + CNT_W'(ren);
            ovf_q  <= fifo_in_valid & full & ~ren;
            udf_q  <= fifo_out_ack & ~fifo_out_valid;
        end
    end

`ifdef CR_KME_FIFO_OUT_REG_EN
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [CNT_W-1:0]  ram_cnt;

    // The output stage holds one entry that is still counted in used_slots.
    assign ram_cnt = used_q - CNT_W'(out_valid_q);
    assign ram_rd  = (ram_cnt != '0) & (~out_valid_q | ren);

    // Output stage refills from storage whenever it is empty or being popped.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (ram_rd) begin
            out_valid_q <= 1'b1;
            out_data_q  <= ram_rd_data;
        end else if (ren) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end
    end

    assign fifo_out_valid = out_valid_q;
    assign fifo_out       = out_data_q;
`else
    assign ram_rd         = ren;
    assign fifo_out_valid = (used_q != '0);
    assign fifo_out       = fifo_out_valid ? ram_rd_data : '0;
`endif

    assign used_slots     = used_q;
    assign free_slots     = free_q;
    assign fifo_overflow  = ovf_q;
    assign fifo_underflow = udf_q;
    assign fifo_in_stall  = (free_q <= RESERVE_C) & ~fifo_in_stall_override;

endmodule

// File: tb/tb_cr_kme_fifo_param.sv
// tb/tb_cr_kme_fifo_param.sv - self-checking bench for cr_kme_fifo_param against a queue model
module tb_cr_kme_fifo_param;

    localparam int DW = 106;
`ifdef CR_KME_FIFO_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, clear = 1'b0, in_valid = 1'b0, ovr = 1'b0, ack = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          stall, out_valid, ovf, udf;
    logic [DW-1:0] out_data;
    logic [2:0]    used, free;

    logic          r_stall, r_valid, r_ovf, r_udf;
    logic [DW-1:0] r_out;
    logic [2:0]    r_used, r_free;

    logic          w_clear = 1'b0, w_in_valid = 1'b0, w_ack = 1'b0, w_ovr = 1'b0;
    logic [DW-1:0] w_in = '0;
    logic          w_stall, w_valid, w_ovf, w_udf;
    logic [DW-1:0] w_out;
    logic [1:0]    w_used, w_free;

    cr_kme_fifo_param #(.DATA_W(DW), .DEPTH(4), .STALL_RESERVE(0)) u_main (
        .clk(clk), .rst(rst), .clear(clear), .fifo_in(in_data), .fifo_in_valid(in_valid),
        .fifo_in_stall_override(ovr), .fifo_in_stall(stall), .fifo_out(out_data),
        .fifo_out_valid(out_valid), .fifo_out_ack(ack), .used_slots(used), .free_slots(free),
        .fifo_overflow(ovf), .fifo_underflow(udf));

    cr_kme_fifo_param #(.DATA_W(DW), .DEPTH(4), .STALL_RESERVE(1)) u_res (
        .clk(clk), .rst(rst), .clear(clear), .fifo_in(in_data), .fifo_in_valid(in_valid),
        .fifo_in_stall_override(ovr), .fifo_in_stall(r_stall), .fifo_out(r_out),
        .fifo_out_valid(r_valid), .fifo_out_ack(ack), .used_slots(r_used), .free_slots(r_free),
        .fifo_overflow(r_ovf), .fifo_underflow(r_udf));

    cr_kme_fifo_param #(.DATA_W(DW), .DEPTH(3), .STALL_RESERVE(0)) u_wrap (
        .clk(clk), .rst(rst), .clear(w_clear), .fifo_in(w_in), .fifo_in_valid(w_in_valid),
        .fifo_in_stall_override(w_ovr), .fifo_in_stall(w_stall), .fifo_out(w_out),
        .fifo_out_valid(w_valid), .fifo_out_ack(w_ack), .used_slots(w_used), .free_slots(w_free),
        .fifo_overflow(w_ovf), .fifo_underflow(w_udf));

    typedef struct {
        logic [DW-1:0] d;
        int            rdy;
    } ent_t;

    ent_t          mq[$];
    int            cyc = 0;
    bit            m_ovf = 1'b0, m_udf = 1'b0;
    int            n_cmp = 0, n_bad = 0;
    logic [DW-1:0] v[5];

    function automatic logic [DW-1:0] rnd();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    // Head is visible once it is oldest and its write latency has elapsed.
    function automatic bit m_vis();
        return (mq.size() > 0) && (mq[0].rdy <= cyc);
    endfunction

    function automatic logic [2:0] m_used();
        return 3'(mq.size());
    endfunction

    // Applies one cycle of inputs to the DUTs and the model, ends at the next falling edge.
    task automatic tick(input bit r, input bit c, input bit iv, input logic [DW-1:0] d,
                        input bit a, input bit o);
        bit   vis, full, rn;
        ent_t e;
        rst = r; clear = c; in_valid = iv; in_data = d; ack = a; ovr = o;
        vis  = m_vis();
        full = (mq.size() == 4);
        rn   = vis & a;
        if (r || c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_ovf = iv & full & ~rn;
            m_udf = a & ~vis;
            if (rn) void'(mq.pop_front());
            if (iv && (!full || rn)) begin
                e.d = d; e.rdy = cyc + 1 + LAT - 1;
                mq.push_back(e);
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        tick(1, 0, 1, rnd(), 1, 0);
        tick(1, 0, 0, '0, 0, 0);
        n_cmp++; if (used !== 3'd0) begin n_bad++; $display("FAIL reset_used: got %0d want 0", used); end
        n_cmp++; if (free !== 3'd4) begin n_bad++; $display("FAIL reset_free: got %0d want 4", free); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", out_data); end
        n_cmp++; if (ovf !== 1'b0 || udf !== 1'b0) begin n_bad++; $display("FAIL reset_pulses: got %b%b want 00", ovf, udf); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++; if (w_used !== 2'd0 || w_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got used %0d valid %b want 0 0", w_used, w_valid); end
        tick(0, 0, 0, '0, 0, 0);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin v[i] = rnd(); tick(0, 0, 1, v[i], 0, 0); end
        n_cmp++; if (used !== 3'd4 || free !== 3'd0) begin n_bad++; $display("FAIL fill_counts: got %0d/%0d want 4/0", used, free); end
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL fill_stall: got %b want 1", stall); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== v[i]) begin n_bad++; $display("FAIL drain_order%0d: got %b %h want 1 %h", i, out_valid, out_data, v[i]); end
            tick(0, 0, 0, '0, 1, 0);
        end
        n_cmp++; if (used !== 3'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %0d %b want 0 0", used, out_valid); end
        tick(0, 0, 0, '0, 0, 0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) v[i] = rnd();
        for (int i = 0; i < 4; i++) tick(0, 0, 1, v[i], 0, 0);
        tick(0, 0, 1, v[4], 0, 0);
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse: got %b want 1", ovf); end
        n_cmp++; if (used !== 3'd4) begin n_bad++; $display("FAIL ovf_used: got %0d want 4", used); end
        tick(0, 0, 0, '0, 0, 0);
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_width: got %b want 0", ovf); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== v[i]) begin n_bad++; $display("FAIL ovf_order%0d: got %b %h want 1 %h", i, out_valid, out_data, v[i]); end
            tick(0, 0, 0, '0, 1, 0);
        end
        n_cmp++; if (used !== 3'd0) begin n_bad++; $display("FAIL ovf_dropped: got used %0d want 0", used); end
        tick(0, 0, 0, '0, 0, 0);
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 5; i++) v[i] = rnd();
        for (int i = 0; i < 4; i++) tick(0, 0, 1, v[i], 0, 0);
        n_cmp++; if (out_data !== v[0]) begin n_bad++; $display("FAIL simul_head: got %h want %h", out_data, v[0]); end
        tick(0, 0, 1, v[4], 1, 0);
        n_cmp++; if (used !== 3'd4) begin n_bad++; $display("FAIL simul_used: got %0d want 4", used); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL simul_ovf: got %b want 0", ovf); end
        for (int i = 1; i < 5; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== v[i]) begin n_bad++; $display("FAIL simul_order%0d: got %b %h want 1 %h", i, out_valid, out_data, v[i]); end
            tick(0, 0, 0, '0, 1, 0);
        end
        tick(0, 0, 0, '0, 0, 0);
    endtask

    task automatic test_reserve_underflow();
        for (int i = 0; i < 3; i++) tick(0, 0, 1, rnd(), 0, 0);
        n_cmp++; if (r_stall !== 1'b1) begin n_bad++; $display("FAIL reserve_stall: got %b want 1", r_stall); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL noreserve_stall: got %b want 0", stall); end
        tick(0, 0, 0, '0, 0, 1);
        n_cmp++; if (r_stall !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL override_stall: got %b%b want 00", r_stall, stall); end
        tick(0, 0, 0, '0, 0, 0);
        n_cmp++; if (r_stall !== 1'b1) begin n_bad++; $display("FAIL override_release: got %b want 1", r_stall); end
        for (int i = 0; i < 10 && mq.size() > 0; i++) tick(0, 0, 0, '0, m_vis(), 0);
        tick(0, 0, 0, '0, 1, 0);
        n_cmp++; if (udf !== 1'b1) begin n_bad++; $display("FAIL udf_pulse: got %b want 1", udf); end
        n_cmp++; if (used !== 3'd0 || free !== 3'd4) begin n_bad++; $display("FAIL udf_state: got %0d/%0d want 0/4", used, free); end
        tick(0, 0, 0, '0, 0, 0);
        n_cmp++; if (udf !== 1'b0) begin n_bad++; $display("FAIL udf_width: got %b want 0", udf); end
    endtask

    task automatic test_clear();
        tick(0, 0, 1, rnd(), 0, 0);
        tick(0, 0, 1, rnd(), 0, 0);
        tick(0, 1, 1, rnd(), 1, 0);
        n_cmp++; if (used !== 3'd0 || free !== 3'd4) begin n_bad++; $display("FAIL clear_counts: got %0d/%0d want 0/4", used, free); end
        n_cmp++; if (ovf !== 1'b0 || udf !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL clear_quiet: got ovf %b udf %b valid %b want 000", ovf, udf, out_valid); end
        v[0] = rnd();
        tick(0, 0, 1, v[0], 0, 0);
        for (int i = 1; i < LAT; i++) tick(0, 0, 0, '0, 0, 0);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== v[0]) begin n_bad++; $display("FAIL clear_refill: got %b %h want 1 %h", out_valid, out_data, v[0]); end
        tick(0, 0, 0, '0, 1, 0);
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 3; i++) tick(0, 0, 1, rnd(), 0, 0);
        tick(1, 1, 1, rnd(), 1, 0);
        n_cmp++; if (used !== 3'd0 || free !== 3'd4 || out_valid !== 1'b0 || out_data !== '0) begin n_bad++; $display("FAIL rst_mid_state: got %0d/%0d %b %h want 0/4 0 0", used, free, out_valid, out_data); end
        n_cmp++; if (ovf !== 1'b0 || udf !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL rst_mid_flags: got %b%b%b want 000", ovf, udf, stall); end
        tick(0, 0, 0, '0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            n_cmp++; if (out_valid !== m_vis()) begin n_bad++; $display("FAIL rnd_valid@%0d: got %b want %b", i, out_valid, m_vis()); end
            if (m_vis()) begin
                n_cmp++; if (out_data !== mq[0].d) begin n_bad++; $display("FAIL rnd_data@%0d: got %h want %h", i, out_data, mq[0].d); end
            end
            n_cmp++; if (used !== m_used() || free !== 3'(4 - mq.size())) begin n_bad++; $display("FAIL rnd_counts@%0d: got %0d/%0d want %0d/%0d", i, used, free, m_used(), 4 - mq.size()); end
            n_cmp++; if (stall !== ((mq.size() == 4) & ~ovr)) begin n_bad++; $display("FAIL rnd_stall@%0d: got %b", i, stall); end
            n_cmp++; if (r_stall !== ((mq.size() >= 3) & ~ovr)) begin n_bad++; $display("FAIL rnd_rstall@%0d: got %b", i, r_stall); end
            n_cmp++; if (ovf !== m_ovf || udf !== m_udf) begin n_bad++; $display("FAIL rnd_pulses@%0d: got %b%b want %b%b", i, ovf, udf, m_ovf, m_udf); end
            tick(0, ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), rnd(),
                 $urandom_range(0, 1), ($urandom_range(0, 7) == 0));
        end
        tick(0, 1, 0, '0, 0, 0);
        tick(0, 0, 0, '0, 0, 0);
    endtask

    task automatic test_wrap();
        logic [DW-1:0] wd[10];
        logic [DW-1:0] sb[$];
        int sent, got, first_valid;
        sent = 0; got = 0; first_valid = -1;
        for (int i = 0; i < 10; i++) wd[i] = rnd();
        for (int c = 0; c < 40 && got < 10; c++) begin
            if (w_valid && first_valid < 0) first_valid = c;
            if (w_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL wrap_spurious@%0d: valid with nothing written", c); end
                else if (w_out !== sb[0]) begin n_bad++; $display("FAIL wrap_data@%0d: got %h want %h", c, w_out, sb[0]); end
            end
            n_cmp++; if (w_used !== 2'(sb.size())) begin n_bad++; $display("FAIL wrap_used@%0d: got %0d want %0d", c, w_used, sb.size()); end
            n_cmp++; if (w_ovf !== 1'b0 || w_udf !== 1'b0) begin n_bad++; $display("FAIL wrap_pulses@%0d: got %b%b want 00", c, w_ovf, w_udf); end
            w_ack      = (c >= 2) && w_valid && (sb.size() > 0);
            w_in_valid = (sent < 10);
            w_in       = (sent < 10) ? wd[sent] : '0;
            if (w_ack) begin void'(sb.pop_front()); got++; end
            if (w_in_valid) begin sb.push_back(wd[sent]); sent++; end
            @(negedge clk);
        end
        w_ack = 1'b0; w_in_valid = 1'b0;
        n_cmp++; if (got !== 10) begin n_bad++; $display("FAIL wrap_count: got %0d want 10", got); end
        n_cmp++; if (first_valid !== LAT) begin n_bad++; $display("FAIL wrap_latency: got %0d want %0d", first_valid, LAT); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simul_full();
        test_reserve_underflow();
        test_clear();
        test_rst_mid();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
